// File: rtl/ram_arbiter.sv
// Two-port (CPU/DMA) arbiter that issues one SDRAM command per PHI2 slot and returns read data.
// Optional macro RAM_ARB_RR_EN replaces fixed CPU priority with round-robin arbitration.
module ram_arbiter #(
  parameter int RDLAT   = 5,
  parameter int SLOTLEN = 8
) (
  input  logic        C8M,
  input  logic        RESET,
  input  logic        PHI2,
  input  logic        CPUREQ,
  input  logic        CPUWR,
  input  logic [23:0] CPUA,
  input  logic [7:0]  CPUWD,
  output logic        CPUACK,
  output logic [7:0]  CPURD,
  input  logic        DMAREQ,
  input  logic        DMAWR,
  input  logic [23:0] DMAA,
  input  logic [7:0]  DMAWD,
  output logic        DMAACK,
  output logic [7:0]  DMARD,
  output logic        RDCMD,
  output logic        WRCMD,
  output logic [23:0] A,
  output logic [7:0]  WRD,
  input  logic [7:0]  RDD
);

  localparam int CW = (SLOTLEN > 1) ? $clog2(SLOTLEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOTLEN - 1);
  localparam logic [CW-1:0] CNT_RD   = CW'(RDLAT);

  typedef enum logic [1:0] {IDLE, ARM, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic          phi2_s1, phi2_s2, phi2_d;
  logic          slot_start;
  logic [CW-1:0] cnt;
  logic          cmd_wr;
  logic          win_dma;
  logic [7:0]    rd_reg;
  logic [7:0]    rd_val;
  logic          any_req;
  logic          grant_dma;
  logic          sel_wr;
  logic [23:0]   sel_a;
  logic [7:0]    sel_wd;

  assign slot_start = phi2_d & ~phi2_s2;
  assign any_req    = CPUREQ | DMAREQ;

`ifdef RAM_ARB_RR_EN
  logic prio_dma;

  always_comb begin
    grant_dma = DMAREQ & (~CPUREQ | prio_dma);
  end
`else
  always_comb begin
    grant_dma = DMAREQ & ~CPUREQ;
  end
`endif

  // Write data is forced to zero for reads so a read never carries the requester's WD.
  always_comb begin
    sel_wr = grant_dma ? DMAWR : CPUWR;
    sel_a  = grant_dma ? DMAA  : CPUA;
    sel_wd = 8'h00;
    if (sel_wr)
      sel_wd = grant_dma ? DMAWD : CPUWD;
  end

  // Read data bypasses the register when the capture count is also the last count.
  always_comb begin
    rd_val = 8'h00;
    if (!cmd_wr)
      rd_val = (cnt == CNT_RD) ? RDD : rd_reg;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge C8M) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)          state_nxt = ARM;
      ARM:     if (slot_start)       state_nxt = BUSY;
      BUSY:    if (cnt == CNT_LAST)  state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C8M) begin
    if (RESET) begin
      phi2_s1 <= 1'b0;
      phi2_s2 <= 1'b0;
      phi2_d  <= 1'b0;
    end else begin
      phi2_s1 <= PHI2;
      phi2_s2 <= phi2_s1;
      phi2_d  <= phi2_s2;
    end
  end

  always_ff @(posedge C8M) begin
    if (RESET) begin
      RDCMD   <= 1'b0;
      WRCMD   <= 1'b0;
      A       <= 24'h0;
      WRD     <= 8'h00;
      CPUACK  <= 1'b0;
      DMAACK  <= 1'b0;
      CPURD   <= 8'h00;
      DMARD   <= 8'h00;
      rd_reg  <= 8'h00;
      cnt     <= '0;
      cmd_wr  <= 1'b0;
      win_dma <= 1'b0;
`ifdef RAM_ARB_RR_EN
      prio_dma <= 1'b0;
`endif
    end else begin
      CPUACK <= 1'b0;
      DMAACK <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win_dma <= grant_dma;
            cmd_wr  <= sel_wr;
            RDCMD   <= ~sel_wr;
            WRCMD   <= sel_wr;
            A       <= sel_a;
            WRD     <= sel_wd;
`ifdef RAM_ARB_RR_EN
            prio_dma <= ~grant_dma;
`endif
          end
        end
        ARM: begin
          if (slot_start)
            cnt <= '0;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          // Drop the strobes after one cycle so the controller sees a single command.
          if (cnt == '0) begin
            RDCMD <= 1'b0;
            WRCMD <= 1'b0;
          end
          if (cnt == CNT_RD && !cmd_wr)
            rd_reg <= RDD;
          if (cnt == CNT_LAST) begin
            CPUACK <= ~win_dma;
            DMAACK <= win_dma;
            if (win_dma)
              DMARD <= rd_val;
            else
              CPURD <= rd_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected commands/acks, a monitor pops and compares.
// A small SDRAM model returns RDD = A[7:0]^0xF3 only in the cycle at count RDLAT.
module tb_ram_arbiter;

  localparam int RDLAT   = 5;
  localparam int SLOTLEN = 8;
  localparam int LAT_MAX = 2 * SLOTLEN + 3;

  logic        C8M, RESET, PHI2;
  logic        CPUREQ, CPUWR, CPUACK;
  logic [23:0] CPUA;
  logic [7:0]  CPUWD, CPURD;
  logic        DMAREQ, DMAWR, DMAACK;
  logic [23:0] DMAA;
  logic [7:0]  DMAWD, DMARD;
  logic        RDCMD, WRCMD;
  logic [23:0] A;
  logic [7:0]  WRD, RDD;

  ram_arbiter #(.RDLAT(RDLAT), .SLOTLEN(SLOTLEN)) dut (
    .C8M(C8M), .RESET(RESET), .PHI2(PHI2),
    .CPUREQ(CPUREQ), .CPUWR(CPUWR), .CPUA(CPUA), .CPUWD(CPUWD),
    .CPUACK(CPUACK), .CPURD(CPURD),
    .DMAREQ(DMAREQ), .DMAWR(DMAWR), .DMAA(DMAA), .DMAWD(DMAWD),
    .DMAACK(DMAACK), .DMARD(DMARD),
    .RDCMD(RDCMD), .WRCMD(WRCMD), .A(A), .WRD(WRD), .RDD(RDD)
  );

  initial C8M = 1'b0;
  always #5 C8M = ~C8M;

  // PHI2 period is one slot, phase deliberately off the C8M grid.
  initial begin
    PHI2 = 1'b0;
    #43;
    forever #40 PHI2 = ~PHI2;
  end

  typedef struct packed { logic dma; logic [7:0] rd; } ack_t;
  typedef struct packed { logic wr; logic [23:0] a; logic [7:0] wd; } cmd_t;

  ack_t ack_q[$];
  cmd_t cmd_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   sb_on = 1'b1;
  int   viol  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    total++;
    if (act > lim) begin
      bad++;
      $display("FAIL %s: got %0d limit %0d", name, act, lim);
    end
  endtask

  // SDRAM model: data valid only in the cycle where the slot counter equals RDLAT.
  logic        prev_rd = 1'b0;
  logic [23:0] rd_addr = 24'h0;
  int          k = 0;
  initial RDD = 8'hEE;
  always @(negedge C8M) begin
    if (RDCMD && !prev_rd) rd_addr = A;
    if (prev_rd && !RDCMD) k = 1;
    else if (k > 0 && k <= RDLAT) k++;
    else k = 0;
    RDD = (k == RDLAT) ? (rd_addr[7:0] ^ 8'hF3) : 8'hEE;
    prev_rd = RDCMD;
  end

  // Monitor: command issue, address stability, acknowledge.
  logic        prev_any = 1'b0;
  logic [23:0] cur_a = 24'h0;
  always @(negedge C8M) begin
    if (RDCMD && WRCMD) viol++;
    if (sb_on) begin
      if ((RDCMD || WRCMD) && !prev_any) begin
        if (cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd: got A=%0h expected none", A);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          cur_a = e.a;
          check("cmd_wr", {31'b0, WRCMD}, {31'b0, e.wr});
          check("cmd_rd", {31'b0, RDCMD}, {31'b0, ~e.wr});
          check("cmd_a", {8'h0, A}, {8'h0, e.a});
          if (e.wr) check("cmd_wd", {24'h0, WRD}, {24'h0, e.wd});
        end
      end
      if (!(RDCMD || WRCMD) && prev_any)
        check("a_stable_busy", {8'h0, A}, {8'h0, cur_a});
      if (CPUACK || DMAACK) begin
        if (CPUACK && DMAACK) begin
          total++; bad++;
          $display("FAIL both_ack: got CPUACK=1 DMAACK=1 expected one");
        end
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got cpu=%0b dma=%0b expected none", CPUACK, DMAACK);
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          check("ack_port", {31'b0, DMAACK}, {31'b0, e.dma});
          check("ack_data", {24'h0, (DMAACK ? DMARD : CPURD)}, {24'h0, e.rd});
          check("a_stable_done", {8'h0, A}, {8'h0, cur_a});
        end
      end
    end
    prev_any = RDCMD || WRCMD;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge C8M);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rdcmd"}, {31'b0, RDCMD}, 32'h0);
    check({tag, "_wrcmd"}, {31'b0, WRCMD}, 32'h0);
    check({tag, "_a"}, {8'h0, A}, 32'h0);
    check({tag, "_wrd"}, {24'h0, WRD}, 32'h0);
    check({tag, "_cpuack"}, {31'b0, CPUACK}, 32'h0);
    check({tag, "_dmaack"}, {31'b0, DMAACK}, 32'h0);
    check({tag, "_cpurd"}, {24'h0, CPURD}, 32'h0);
    check({tag, "_dmard"}, {24'h0, DMARD}, 32'h0);
  endtask

  // Single uncontended transaction; optionally drops the request while the command is armed.
  task automatic txn(input bit dma, input bit wr, input logic [23:0] a, input logic [7:0] wd,
                     input logic [7:0] exp_rd, input bit drop_early);
    int lat;
    bit got;
    cmd_q.push_back('{wr: wr, a: a, wd: wd});
    ack_q.push_back('{dma: dma, rd: exp_rd});
    if (dma) begin DMAWR = wr; DMAA = a; DMAWD = wd; DMAREQ = 1'b1; end
    else     begin CPUWR = wr; CPUA = a; CPUWD = wd; CPUREQ = 1'b1; end
    lat = 0;
    got = 1'b0;
    if (drop_early) begin
      tick(1);
      lat = 1;
      if (dma) DMAREQ = 1'b0; else CPUREQ = 1'b0;
    end
    while (!got && lat < 200) begin
      @(negedge C8M);
      lat++;
      if (dma ? DMAACK : CPUACK) got = 1'b1;
    end
    if (dma) DMAREQ = 1'b0; else CPUREQ = 1'b0;
    check("ack_seen", {31'b0, got}, 32'h1);
    check_le("latency", lat, LAT_MAX);
    tick(3);
  endtask

  // Both ports request; each ack after the third lowers that port's request.
  task automatic contend(input int n_grants, input int lower_from);
    int grants;
    int cyc;
    grants = 0;
    cyc = 0;
    CPUREQ = 1'b1;
    DMAREQ = 1'b1;
    while (grants < n_grants && cyc < 1000) begin
      @(negedge C8M);
      cyc++;
      if (CPUACK) begin grants++; if (grants >= lower_from) CPUREQ = 1'b0; end
      if (DMAACK) begin grants++; if (grants >= lower_from) DMAREQ = 1'b0; end
    end
    CPUREQ = 1'b0;
    DMAREQ = 1'b0;
    check("contend_grants", grants, n_grants);
    tick(3);
  endtask

  initial begin
    int cyc;
    bit fell;
    RESET = 1'b1;
    CPUREQ = 1'b0; CPUWR = 1'b0; CPUA = 24'h0; CPUWD = 8'h00;
    DMAREQ = 1'b0; DMAWR = 1'b0; DMAA = 24'h0; DMAWD = 8'h00;
    tick(3);
    check_outputs_zero("reset");
    RESET = 1'b0;
    tick(2);

    // CPU read: 0x56 ^ 0xF3 = 0xA5; WD junk must not matter.
    txn(1'b0, 1'b0, 24'h123456, 8'h99, 8'hA5, 1'b0);
    // DMA write: ack with RD 0x00.
    txn(1'b1, 1'b1, 24'h000001, 8'h3C, 8'h00, 1'b0);

    // Same-cycle contention, one transaction each: CPU first, then DMA.
    CPUWR = 1'b0; CPUA = 24'h000010; CPUWD = 8'h11;
    DMAWR = 1'b0; DMAA = 24'h000020; DMAWD = 8'h22;
    cmd_q.push_back('{wr: 1'b0, a: 24'h000010, wd: 8'h11});
    cmd_q.push_back('{wr: 1'b0, a: 24'h000020, wd: 8'h22});
    ack_q.push_back('{dma: 1'b0, rd: 8'hE3});
    ack_q.push_back('{dma: 1'b1, rd: 8'hD3});
    contend(2, 1);

    // Held contention: three rounds with both requesting, then CPU drops and DMA drains.
`ifdef RAM_ARB_RR_EN
    cmd_q.push_back('{wr: 1'b0, a: 24'h000010, wd: 8'h11});
    cmd_q.push_back('{wr: 1'b0, a: 24'h000020, wd: 8'h22});
    cmd_q.push_back('{wr: 1'b0, a: 24'h000010, wd: 8'h11});
    ack_q.push_back('{dma: 1'b0, rd: 8'hE3});
    ack_q.push_back('{dma: 1'b1, rd: 8'hD3});
    ack_q.push_back('{dma: 1'b0, rd: 8'hE3});
`else
    cmd_q.push_back('{wr: 1'b0, a: 24'h000010, wd: 8'h11});
    cmd_q.push_back('{wr: 1'b0, a: 24'h000010, wd: 8'h11});
    cmd_q.push_back('{wr: 1'b0, a: 24'h000010, wd: 8'h11});
    ack_q.push_back('{dma: 1'b0, rd: 8'hE3});
    ack_q.push_back('{dma: 1'b0, rd: 8'hE3});
    ack_q.push_back('{dma: 1'b0, rd: 8'hE3});
`endif
    cmd_q.push_back('{wr: 1'b0, a: 24'h000020, wd: 8'h22});
    ack_q.push_back('{dma: 1'b1, rd: 8'hD3});
    contend(4, 3);

    // Early release: 0xAB ^ 0xF3 = 0x58.
    txn(1'b0, 1'b0, 24'h0000AB, 8'h00, 8'h58, 1'b1);

    // Reset at slot count 3: command abandoned, no ack, outputs cleared.
    cmd_q.push_back('{wr: 1'b0, a: 24'h0000C0, wd: 8'h00});
    CPUWR = 1'b0; CPUA = 24'h0000C0; CPUWD = 8'h00; CPUREQ = 1'b1;
    cyc = 0;
    fell = 1'b0;
    while (!fell && cyc < 200) begin
      @(negedge C8M);
      cyc++;
      if (prev_any && !RDCMD) fell = 1'b1;
    end
    check("busy_reached", {31'b0, fell}, 32'h1);
    @(negedge C8M);
    @(negedge C8M);
    RESET = 1'b1;
    CPUREQ = 1'b0;
    @(posedge C8M);
    #1;
    check_outputs_zero("busy_reset");
    tick(1);
    RESET = 1'b0;
    tick(3 * SLOTLEN);
    check("no_ack_after_reset", ack_q.size(), 0);

    // Random traffic: only the RDCMD/WRCMD exclusivity invariant is checked.
    sb_on = 1'b0;
    for (int i = 0; i < 1000 * SLOTLEN; i++) begin
      tick(1);
      if (CPUREQ && CPUACK) CPUREQ = 1'b0;
      else if (!CPUREQ && $urandom_range(3) == 0) begin
        CPUWR = 1'($urandom_range(1)); CPUA = 24'($urandom); CPUWD = 8'($urandom); CPUREQ = 1'b1;
      end
      if (DMAREQ && DMAACK) DMAREQ = 1'b0;
      else if (!DMAREQ && $urandom_range(3) == 0) begin
        DMAWR = 1'($urandom_range(1)); DMAA = 24'($urandom); DMAWD = 8'($urandom); DMAREQ = 1'b1;
      end
    end
    CPUREQ = 1'b0;
    DMAREQ = 1'b0;
    tick(5 * SLOTLEN);
    check("cmd_exclusive", viol, 0);
    check("cmd_queue_empty", cmd_q.size(), 0);
    check("ack_queue_empty", ack_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
